// File: rtl/seven_stage_memory_arbiter_pkg.sv
// ============================================================================
// Module      : seven_stage_memory_arbiter_pkg
// Description : Shared tag/state encodings and log2 helper for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seven_stage_memory_arbiter_pkg;

  localparam logic TAG_FETCH = 1'b0;
  localparam logic TAG_DATA  = 1'b1;

  typedef enum logic [0:0] {
    PRIO_DATA  = 1'b0,
    PRIO_FETCH = 1'b1
  } arb_state_e;

  // Ceiling log2; exact for the power-of-two queue depth.
  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seven_stage_memory_arbiter_tag_fifo.sv
// ============================================================================
// Module      : arbiter_tag_fifo
// Description : 1-bit synchronous FIFO recording the source of each request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter_tag_fifo
  import seven_stage_memory_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   tag_i,
  output logic                   tag_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [log2(DEPTH):0]   count_o
);

  localparam int PW = log2(DEPTH);
  localparam logic [PW-1:0] C_PTR_ONE = PW'(1);
  localparam logic [PW:0]   C_CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   C_DEPTH   = (PW + 1)'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == C_DEPTH);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign tag_o   = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
      if (do_push && !do_pop)      count_q <= count_q + C_CNT_ONE;
      else if (!do_push && do_pop) count_q <= count_q - C_CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= tag_i;
  end

endmodule

`default_nettype wire

// File: rtl/seven_stage_memory_arbiter.sv
// ============================================================================
// Module      : seven_stage_memory_arbiter
// Description : Data-first fetch/data arbiter for one pipelined memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_stage_memory_arbiter
  import seven_stage_memory_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 20,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             i_read,
  input  logic [ADDRESS_BITS-1:0]          i_address,
  output logic                             i_ready,
  output logic                             i_valid,
  output logic [DATA_WIDTH-1:0]            i_data_out,
  output logic [ADDRESS_BITS-1:0]          i_address_out,
  input  logic                             d_read,
  input  logic                             d_write,
  input  logic [ADDRESS_BITS-1:0]          d_address,
  input  logic [DATA_WIDTH-1:0]            d_data_in,
  output logic                             d_ready,
  output logic                             d_valid,
  output logic [DATA_WIDTH-1:0]            d_data_out,
  output logic [ADDRESS_BITS-1:0]          d_address_out,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDRESS_BITS-1:0]          mem_address,
  output logic [DATA_WIDTH-1:0]            mem_data_in,
  input  logic                             mem_ready,
  input  logic                             mem_valid,
  input  logic [DATA_WIDTH-1:0]            mem_data_out,
  input  logic [ADDRESS_BITS-1:0]          mem_address_out,
  output logic [log2(MAX_OUTSTANDING):0]   outstanding,
  output logic                             protocol_error
);

  localparam int CW = log2(STARVE_LIMIT) + 1;
  localparam logic [CW-1:0] C_STARVE  = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          perr_q;

  logic fifo_full, fifo_empty, head_tag;
  logic data_req, can_issue, grant_f, grant_d, push, pop;

  assign data_req  = d_read || d_write;
  assign can_issue = !fifo_full && !reset;

  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (can_issue) begin
      if (state_q == PRIO_FETCH) begin
        grant_f = i_read;
        grant_d = !i_read && data_req;
      end else begin
        grant_d = data_req;
        grant_f = !data_req && i_read;
      end
    end
  end

  assign mem_read    = grant_f || (grant_d && d_read);
  assign mem_write   = grant_d && d_write;
  assign mem_address = grant_f ? i_address : d_address;
  assign mem_data_in = d_data_in;
  assign i_ready     = grant_f && mem_ready;
  assign d_ready     = grant_d && mem_ready;

  // Stores never answer, so only loads and fetches occupy a tag slot.
  assign push = i_ready || (d_ready && d_read);
  assign pop  = mem_valid && !fifo_empty && !reset;

  assign i_valid       = pop && (head_tag == TAG_FETCH);
  assign d_valid       = pop && (head_tag == TAG_DATA);
  assign i_data_out    = mem_data_out;
  assign d_data_out    = mem_data_out;
  assign i_address_out = mem_address_out;
  assign d_address_out = mem_address_out;
  assign protocol_error = perr_q;

  arbiter_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .tag_i   (d_ready ? TAG_DATA : TAG_FETCH),
    .tag_o   (head_tag),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding)
  );

  always_comb begin
    starve_d = starve_q;
    state_d  = state_q;
    if (i_ready) begin
      starve_d = '0;
      state_d  = PRIO_DATA;
    end else if (!i_read) begin
      starve_d = '0;
    end else if (d_ready && starve_q < C_STARVE) begin
      starve_d = starve_q + C_CNT_ONE;
    end
    if (!i_ready && starve_d >= C_STARVE) state_d = PRIO_FETCH;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= PRIO_DATA;
      starve_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (mem_valid && fifo_empty) perr_q <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: doc/seven_stage_memory_arbiter.md
# seven_stage_memory_arbiter

Shares one pipelined memory port between the seven-stage core's instruction fetch issue stage and data memory issue stage. Arbitrates between them with data-first priority and a starvation guard, tracks the source of every outstanding request in an in-order tag queue, and routes returning responses to the fetch receive or memory receive stage. Its per-port ready and valid outputs feed the core's hazard detection unit as fetch_ready/fetch_valid and memory_ready/memory_valid.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width
- ADDRESS_BITS, 20, address width
- MAX_OUTSTANDING, 4, tag queue depth (power of two, at least 2)
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits

Ports (clock `clock`, one domain; reset `reset` synchronous, active-high):
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- i_read  in  1  fetch read request
- i_address  in  ADDRESS_BITS  fetch address
- i_ready  out  1  fetch request accepted this cycle
- i_valid  out  1  fetch response valid
- i_data_out  out  DATA_WIDTH  fetch response data
- i_address_out  out  ADDRESS_BITS  fetch response address
- d_read, d_write  in  1 each  data load / store request (mutually exclusive)
- d_address  in  ADDRESS_BITS  data address
- d_data_in  in  DATA_WIDTH  store data
- d_ready  out  1  data request accepted this cycle
- d_valid  out  1  data response valid
- d_data_out  out  DATA_WIDTH  data response data
- d_address_out  out  ADDRESS_BITS  data response address
- mem_read, mem_write  out  1 each  shared port request
- mem_address  out  ADDRESS_BITS  shared port address
- mem_data_in  out  DATA_WIDTH  shared port store data
- mem_ready  in  1  memory accepts the request this cycle
- mem_valid  in  1  memory response valid; responses return in order
- mem_data_out  in  DATA_WIDTH  response data
- mem_address_out  in  ADDRESS_BITS  response address
- outstanding  out  log2(MAX_OUTSTANDING)+1  entries in the tag queue
- protocol_error  out  1  sticky; set by a response while the queue is empty

## Operation
- Arbitration state is PRIO_DATA or PRIO_FETCH. The state resets to PRIO_DATA.
- Requests can issue only when the tag queue is not full. A pop in the same cycle does not unblock a full queue, so there is no mem_valid-to-mem_read path.
- Grant rule: the priority port wins if it is requesting. Otherwise the other port wins if it is requesting.
- The granted request is driven onto mem_*. The other port sees ready=0.
- Acceptance happens when the request is granted and mem_ready=1. On acceptance: x_ready=1 and the source tag is pushed (0 for fetch, 1 for data).
- A store (d_write) does not return a response, so it pushes no tag.
- Starvation counter: increments on each accepted data request while i_read=1. It clears on fetch acceptance or when i_read=0.
- When the counter reaches STARVE_LIMIT, the state moves to PRIO_FETCH. The state returns to PRIO_DATA, and the counter clears, after the next fetch acceptance.
- Response path: on mem_valid, the head tag selects i_valid or d_valid. Data and address pass through to both ports unchanged, and the head is popped.
- If mem_valid arrives with an empty queue, the response is dropped and protocol_error is set. protocol_error clears only on reset.
- Reset mid-operation:
  - the queue empties;
  - responses arriving later are dropped and flagged;
  - the memory must be reset together with the arbiter.

## Timing
- Request path is combinational: i/d request to mem_* in the same cycle, and mem_ready to x_ready in the same cycle.
- Response path is combinational: mem_valid to x_valid in the same cycle.
- Tag queue, counter and state update on the rising edge of `clock`.
- Reset values:
  - mem_read, mem_write, i_ready, d_ready, i_valid and d_valid are 0 while reset=1;
  - outstanding=0, protocol_error=0, state=PRIO_DATA, counter=0.
- A push and a pop in the same cycle leave `outstanding` unchanged. The write and read pointers wrap modulo MAX_OUTSTANDING.

## Structure
- Shared package holds:
  - tag encodings TAG_FETCH=0 and TAG_DATA=1;
  - state encodings PRIO_DATA and PRIO_FETCH;
  - the log2 function.
- One sub-module, `arbiter_tag_fifo`: a 1-bit-wide synchronous FIFO of depth MAX_OUTSTANDING with full, empty and count outputs.
- Arbitration, the starvation counter and response steering stay in the top level.

## Test plan
- Idle after reset: all outputs 0, outstanding=0. Then i_read=1 at 0x40 with mem_ready=1 → mem_read=1, mem_address=0x40, i_ready=1, outstanding=1.
- Fetch and data load both request: d_read wins with d_ready=1 and i_ready=0. Responses return in order: the first returns d_valid=1, the second i_valid=1, each carrying its data word (e.g. 0xDEADBEEF).
- Fetch and load request continuously with STARVE_LIMIT=4: data is granted 4 times, then fetch once, then data resumes. Check that the counter clears when i_read drops.
- Queue fill: 4 loads accepted with no response → 5th request sees d_ready=0 even when mem_valid=1 in the same cycle; the request issues the following cycle.
- Store with d_write=1: accepted, outstanding unchanged. A response with an empty queue sets protocol_error=1, which stays set until reset.
- Assert reset with 3 outstanding: outstanding=0 the next cycle. A later mem_valid sets protocol_error and raises neither i_valid nor d_valid.
